// File: rtl/on_time_meter_pkg.sv
// Shared types and default parameter values for the ON-time meter.
package on_time_meter_pkg;

  localparam int unsigned LEN_W_DEF   = 8;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned MIN_LEN_DEF = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/on_time_fifo.sv
// Result FIFO for the ON-time meter: power-of-two depth, pointers wrap
// naturally, a pop on a non-empty FIFO frees room for a same-edge push.
module on_time_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write on accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/on_time_meter.sv
// ON-time meter: measures the number of rising edges din stays high and
// queues each completed length into a small FIFO.
// Optional build macro: ON_TIME_MIN_FILTER_EN drops intervals shorter than
// MIN_LEN edges.
module on_time_meter
  import on_time_meter_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned MIN_LEN = MIN_LEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN_W-1:0] out_len,
  output logic             overflow
);

`ifdef ON_TIME_MIN_FILTER_EN
  localparam logic FILTER_EN = 1'b1;
`else
  localparam logic FILTER_EN = 1'b0;
`endif

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             push_req;
  logic             keep;
  logic             pop;
  logic             full;
  logic             empty;

  assign keep      = ~FILTER_EN | (cnt >= MIN_L);
  assign busy      = (state == COUNT);
  assign out_valid = ~empty;
  assign pop       = out_ready & out_valid;

  // State and length counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, saturating count and push request on the falling level.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push_req  = 1'b0;
    case (state)
      IDLE: begin
        if (din) begin
          state_nxt = COUNT;
          cnt_nxt   = LEN_W'(1);
        end
      end
      COUNT: begin
        if (din) begin
          if (cnt != '1) cnt_nxt = cnt + 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          push_req  = keep;
        end
      end
    endcase
  end

  // Sticky drop flag: a push into a full FIFO with no same-edge pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (push_req && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  on_time_fifo #(
    .WIDTH(LEN_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .wdata (cnt),
    .rdata (out_len),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: doc/on_time_meter.md
ON_TIME_METER -- requirements
Module: on_time_meter

Interface
REQ-001 SHALL have parameter LEN_W, default 8, the width of the measured-length field.
REQ-002 SHALL have parameter DEPTH, default 4, the result FIFO depth; power of two, at least 2.
REQ-003 SHALL have parameter MIN_LEN, default 2, the shortest ON interval kept when filtering is compiled in.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port din, input, 1, the registered ON/OFF level from the upstream j/k state machine.
REQ-007 SHALL have port busy, output, 1, high while an ON interval is being measured.
REQ-008 SHALL have port out_valid, output, 1, high when the FIFO holds at least one result.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the head result.
REQ-010 SHALL have port out_len, output, LEN_W, the head result; held stable while out_valid is high and out_ready is low.
REQ-011 SHALL have port overflow, output, 1, sticky flag for a dropped result.

Function
REQ-012 SHALL implement a two-state measurement FSM with states IDLE and COUNT.
REQ-013 IDLE with din=1 at an edge SHALL go to COUNT and load cnt=1; IDLE with din=0 SHALL stay in IDLE.
REQ-014 COUNT with din=1 SHALL hold state and set cnt=cnt+1, saturating at 2^LEN_W-1 without wrap.
REQ-015 COUNT with din=0 SHALL push cnt into the FIFO at that edge and return to IDLE; a pulse sampled high on N edges yields length N.
REQ-016 busy SHALL equal (state==COUNT) and be registered.
REQ-017 A pushed result SHALL make out_valid high in the cycle after the push edge (one-cycle latency).
REQ-018 A pop SHALL occur at an edge where out_valid=1 and out_ready=1; out_ready while out_valid=0 SHALL have no effect.
REQ-019 A push when the FIFO is full and no pop occurs at the same edge SHALL discard the result and set overflow=1.
REQ-020 A push and a pop at the same edge when the FIFO is full SHALL accept both, leaving the count unchanged and overflow unchanged.
REQ-021 A push and a pop at the same edge when the FIFO holds one entry SHALL keep out_valid high and present the new entry next cycle.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; results SHALL leave in arrival order.

Reset
REQ-023 reset=1 SHALL immediately force state=IDLE, cnt=0, busy=0, out_valid=0, out_len=0, overflow=0 and empty the FIFO, independent of clk.
REQ-024 Reset during COUNT SHALL discard the interval in progress; no result is pushed.
REQ-025 After reset is released, a din already high at the first edge SHALL start a new measurement at cnt=1.
REQ-026 overflow SHALL clear only on reset.

Configuration
REQ-027 With macro ON_TIME_MIN_FILTER_EN defined, a completed interval with cnt<MIN_LEN SHALL be discarded, with no push and no overflow effect.
REQ-028 Without ON_TIME_MIN_FILTER_EN, every completed interval SHALL be pushed and MIN_LEN SHALL be unused.

Structure
REQ-029 SHALL place the state enum typedef (IDLE, COUNT) and the default LEN_W/DEPTH/MIN_LEN constants in package on_time_meter_pkg.
REQ-030 SHALL put the FIFO in sub-module on_time_fifo with push/pop/full/empty ports; the FSM and counter SHALL stay in on_time_meter.

Verification
REQ-031 Reset released, din high on 3 edges then low -> out_len=3, out_valid high the next cycle; out_ready=1 -> out_valid=0 the following cycle.
REQ-032 Five 1-edge-spaced pulses of lengths 2,3,4,5,6 with out_ready=0 -> FIFO holds 2,3,4,5, the 6 is dropped and overflow=1; drain -> 2,3,4,5 in order.
REQ-033 din high for 300 edges with LEN_W=8 -> out_len=255.
REQ-034 reset asserted mid-COUNT between clock edges -> busy=0 at once, no result later appears, overflow=0.
REQ-035 Full FIFO with out_ready=1 as a new result arrives -> no drop, overflow stays 0, count stays 4.
REQ-036 1-edge pulse -> out_len=1 without ON_TIME_MIN_FILTER_EN; no output with it defined and MIN_LEN=2.
